conv_frame_encoder: RTL
=======================

Name: conv_frame_encoder

Overview:
Rate-1/2 feed-forward convolutional encoder with frame termination; the transmit-side partner of the existing Viterbi decoder in the tx/rx loopback.
- Accepts one data bit per handshake and emits one 2-bit code symbol per bit.
- After FRAME_LEN data bits, it appends K-1 zero tail bits so the decoder's trellis ends in state 0.
- Sits between the bit source and the channel/error-injection stage. Its valid_o directly drives the decoder enable path.

Parameters:
- K, 3: constraint length; legal range 3..7; the encoder holds K-1 state bits.
- G0, 3'b111: generator polynomial for d_out[1], K bits wide.
- G1, 3'b101: generator polynomial for d_out[0], K bits wide.
- FRAME_LEN, 64: data bits per frame; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enable_i  input  1  source offers d_in this cycle.
- d_in  input  1  data bit.
- ready_o  output  1  encoder can accept a data bit this cycle.
- valid_o  output  1  d_out holds a valid code symbol.
- d_out  output  2  code symbol {g0_parity, g1_parity}.
- sof_o  output  1  qualifies the first symbol of a frame.
- eof_o  output  1  qualifies the last tail symbol of a frame.

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register sr=0, bit counter=0, tail counter=0. Outputs: valid_o=0, d_out=2'b00, sof_o=0, eof_o=0, ready_o=1. Asserting rst mid-frame abandons the frame; there is no partial tail.
- Acceptance: a bit is accepted when enable_i && ready_o. ready_o is a function of state only: 1 in IDLE and DATA, 0 in TAIL. It never depends on enable_i.
- Encoding:
  - u = {x, sr[K-2:0]}, where x is the current input bit (d_in, or 0 during the tail) and sr[K-2] is the most recent prior bit.
  - d_out[1] = ^(u & G0); d_out[0] = ^(u & G1).
  - Next sr = u[K-1:1].
- Latency: the symbol for a bit accepted at edge t is registered on edge t. valid_o is high for exactly one cycle per encoded bit.
- Cycles with no acceptance in IDLE/DATA: valid_o=0, d_out holds its last value, sr and counters hold.
- States:
  - IDLE: sr is 0. On acceptance, encode the bit, set sof_o=1 with that symbol, and set bit counter=1. Go to DATA, or go directly to TAIL if FRAME_LEN==1.
  - DATA: on acceptance, encode the bit and increment the counter. When the accepted bit is bit number FRAME_LEN, clear the counter and go to TAIL.
  - TAIL: on each of K-1 consecutive cycles, encode x=0 with valid_o=1. Input is never stalled or accepted. On the (K-1)th tail symbol, set eof_o=1 and go to IDLE. sr is then 0 by construction; it is also forced to 0 on that transition.
- Frame timing: if the last data bit is accepted at edge t, ready_o is low for cycles t+1..t+K-1, valid tail symbols appear at t+1..t+K-1, and ready_o is high again at t+K. Minimum frame period is FRAME_LEN+K-1 cycles.
- Flag timing: sof_o and eof_o are single-cycle pulses, only ever high together with valid_o. They are never both high for the same symbol, because the tail is at least 2 symbols.
- Counter width is $clog2(FRAME_LEN+1). The tail counter width is $clog2(K).
- Illegal parameters (K outside 3..7, FRAME_LEN < 1) raise an elaboration-time $error.

Decomposition:
- Package viterbi_pkg holds:
  - defaults K_DEF=3, G0_DEF=3'b111, G1_DEF=3'b101;
  - typedef enc_state_t enum {IDLE, DATA, TAIL};
  - typedef symbol_t logic[1:0].
- The decoder imports the same generator constants.
- One sub-module: conv_parity, a combinational unit taking u and a generator and returning a parity bit. It is instantiated twice, for G0 and G1.

Test Plan:
- Reset behaviour: assert rst mid-cycle with enable_i=1 -> valid_o=0, d_out=00, ready_o=1 immediately, without waiting for a clock edge.
- Known vector: K=3, FRAME_LEN=4, bits 1,0,1,1 presented back-to-back -> d_out sequence is 11,10,00,01 followed by tail 01,11. sof_o is high on the first symbol, eof_o on the last. ready_o is low for exactly 2 cycles.
- Stalls: same frame with enable_i toggled 1,0,0,1,0,1,1 -> identical symbol sequence. valid_o is low on the idle cycles and d_out is held.
- Back-to-back frames: FRAME_LEN=4, enable_i held 1 for 3 frames -> each frame is 6 symbols; the second frame starts from sr=0 and its first symbol equals {d_in,d_in}. Bits offered during TAIL are not consumed.
- Reset mid-frame: rst after 2 data bits, then a new frame of 1,0,1,1 -> output matches the known vector exactly, with no leftover tail.
- Loopback: random frames through encoder, clean channel and decoder -> decoded bits equal source bits. With the FRAME_LEN=1, K=7 variant -> 1 data symbol and 6 tail symbols, eof_o on the 7th symbol.

Source files
------------

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared convolutional code constants and types
package viterbi_pkg;
   localparam int         K_DEF  = 3;
   localparam logic [2:0] G0_DEF = 3'b111;
   localparam logic [2:0] G1_DEF = 3'b101;

   typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;
   typedef logic [1:0] symbol_t;
endpackage

// File: rtl/conv_parity.sv
// rtl/conv_parity.sv - parity of the encoder window masked by one generator
module conv_parity #(
   parameter int K = 3
) (
   input  logic [K-1:0] u_i,
   input  logic [K-1:0] g_i,
   output logic         p_o
);
   assign p_o = ^(u_i & g_i);
endmodule

// File: rtl/conv_frame_encoder.sv
// rtl/conv_frame_encoder.sv - rate-1/2 convolutional encoder with zero-tail frame termination
module conv_frame_encoder
   import viterbi_pkg::*;
#(
   parameter int             K         = K_DEF,
   parameter logic [K-1:0]   G0        = K'(G0_DEF),
   parameter logic [K-1:0]   G1        = K'(G1_DEF),
   parameter int             FRAME_LEN = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_i,
   input  logic       d_in,
   output logic       ready_o,
   output logic       valid_o,
   output logic [1:0] d_out,
   output logic       sof_o,
   output logic       eof_o
);
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam int TW = $clog2(K);
   localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN - 1);
   localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

   if (K < 3 || K > 7) begin : g_bad_k
      $error("conv_frame_encoder: K must be within 3..7");
   end
   if (FRAME_LEN < 1) begin : g_bad_len
      $error("conv_frame_encoder: FRAME_LEN must be at least 1");
   end

   enc_state_t    state_q, state_d;
   logic [K-2:0]  sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tail_q, tail_d;
   symbol_t       dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          sof_q, sof_d;
   logic          eof_q, eof_d;

   logic          accept;
   logic          x;
   logic [K-1:0]  u;
   logic          p0, p1;

   assign ready_o = (state_q != TAIL);
   assign accept  = enable_i && ready_o;
   // Tail cycles shift zeros in so the trellis ends in state 0.
   assign x       = (state_q == TAIL) ? 1'b0 : d_in;
   assign u       = {x, sr_q};

   conv_parity #(.K(K)) u_par_g0 (.u_i(u), .g_i(G0), .p_o(p0));
   conv_parity #(.K(K)) u_par_g1 (.u_i(u), .g_i(G1), .p_o(p1));

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      tail_d  = tail_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               valid_d = 1'b1;
               sof_d   = 1'b1;
               dout_d  = {p0, p1};
               sr_d    = u[K-1:1];
               if (FRAME_LEN == 1) begin
                  cnt_d   = '0;
                  state_d = TAIL;
               end else begin
                  cnt_d   = CW'(1);
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               valid_d = 1'b1;
               dout_d  = {p0, p1};
               sr_d    = u[K-1:1];
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = TAIL;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         TAIL: begin
            valid_d = 1'b1;
            dout_d  = {p0, p1};
            if (tail_q == LAST_TAIL) begin
               eof_d   = 1'b1;
               tail_d  = '0;
               sr_d    = '0;
               state_d = IDLE;
            end else begin
               tail_d = tail_q + TW'(1);
               sr_d   = u[K-1:1];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         tail_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         tail_q  <= tail_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
      end
   end

   assign valid_o = valid_q;
   assign d_out   = dout_q;
   assign sof_o   = sof_q;
   assign eof_o   = eof_q;
endmodule
